alu_cc_unit: RTL and testbench

- Parametrised, registered Y86 execute-stage ALU. Generalises the combinational XOR-with-flags block to all four Y86 OPq functions (addq, subq, andq, xorq).
- Adds an architectural condition-code (CC) register with set_cc gating.
- Adds jXX/cmovXX condition evaluation against the committed CC.
- Adds a valid/ready handshake with a one-deep output register, so the unit drops into the pipelined processor between decode and memory stages.

---
 rtl/y86_alu_pkg.sv | 45 ++++
 rtl/alu_core.sv | 40 ++++
 rtl/alu_cc_unit.sv | 101 ++++++++++
 tb/tb_alu_cc_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_alu_pkg.sv
// Y86 execute-stage ALU shared definitions.
// Function codes, condition codes and CC layout.
package y86_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_LE     = 4'd1;
  localparam logic [3:0] COND_L      = 4'd2;
  localparam logic [3:0] COND_E      = 4'd3;
  localparam logic [3:0] COND_NE     = 4'd4;
  localparam logic [3:0] COND_GE     = 4'd5;
  localparam logic [3:0] COND_G      = 4'd6;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;

  localparam logic [0:2] CC_RESET = 3'b100;

  function automatic logic cond_eval(
    input logic [0:2] c,
    input logic [3:0] f
  );
    logic lt;
    logic res;
    lt = c[CC_SF] ^ c[CC_OF];
    res = 1'b0;
    unique case (1'b1)
      (f == COND_ALWAYS): res = 1'b1;
      (f == COND_LE):     res = lt | c[CC_ZF];
      (f == COND_L):      res = lt;
      (f == COND_E):      res = c[CC_ZF];
      (f == COND_NE):     res = !c[CC_ZF];
      (f == COND_GE):     res = !lt;
      (f == COND_G):      res = !lt && !c[CC_ZF];
      default:            res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational Y86 OPq datapath with flags.
// Bit 0 of every operand is the MSB.
module alu_core
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       alu_fun,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic [0:WIDTH-1] r,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             fun_err
);

  // Result, flags and illegal-function detect
  always_comb begin
    r       = '0;
    of      = 1'b0;
    fun_err = 1'b0;
    unique case (1'b1)
      (alu_fun == ALU_ADD): begin
        r  = b + a;
        of = (a[0] == b[0]) && (r[0] != a[0]);
      end
      (alu_fun == ALU_SUB): begin
        r  = b - a;
        of = (a[0] != b[0]) && (r[0] != b[0]);
      end
      (alu_fun == ALU_AND): r = b & a;
      (alu_fun == ALU_XOR): r = b ^ a;
      default: fun_err = 1'b1;
    endcase
    zf = (r == '0);
    sf = r[0];
  end

endmodule

// File: rtl/alu_cc_unit.sv
// Registered Y86 ALU with CC register,
// condition evaluation and valid/ready output.
module alu_cc_unit
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_fun,
  input  logic [0:WIDTH-1] val_a,
  input  logic [0:WIDTH-1] val_b,
  input  logic             set_cc,
  input  logic [3:0]       cond_fun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] val_e,
  output logic             cnd,
  output logic             err,
  output logic [0:2]       cc
);

  logic [0:WIDTH-1] r;
  logic             zf;
  logic             sf;
  logic             of;
  logic             fun_err;
  logic             cond_err;
  logic             op_err;
  logic             accept;

  logic             valid_q, valid_d;
  logic [0:WIDTH-1] val_e_q, val_e_d;
  logic             cnd_q, cnd_d;
  logic             err_q, err_d;
  logic [0:2]       cc_q, cc_d;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .alu_fun (alu_fun),
    .a       (val_a),
    .b       (val_b),
    .r       (r),
    .zf      (zf),
    .sf      (sf),
    .of      (of),
    .fun_err (fun_err)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign cond_err = (cond_fun > COND_G);
  assign op_err   = fun_err || cond_err;

  // Next-state: output register, handshake and CC
  always_comb begin
    valid_d = valid_q;
    val_e_d = val_e_q;
    cnd_d   = cnd_q;
    err_d   = err_q;
    cc_d    = cc_q;
    if (accept) begin
      valid_d = 1'b1;
      err_d   = op_err;
      val_e_d = op_err ? '0 : r;
      cnd_d   = op_err ? 1'b0
                       : cond_eval(cc_q, cond_fun);
      if (set_cc && !op_err)
        cc_d = {zf, sf, of};
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      val_e_q <= '0;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
      cc_q    <= CC_RESET;
    end else begin
      valid_q <= valid_d;
      val_e_q <= val_e_d;
      cnd_q   <= cnd_d;
      err_q   <= err_d;
      cc_q    <= cc_d;
    end
  end

  assign out_valid = valid_q;
  assign val_e     = val_e_q;
  assign cnd       = cnd_q;
  assign err       = err_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_cc_unit.sv
// Scoreboard bench for alu_cc_unit.
// Covers WIDTH=64 and a WIDTH=8 instance.
module tb_alu_cc_unit;

  typedef struct {
    logic [63:0] v;
    logic        c;
    logic        e;
    logic [2:0]  cc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_fun = 4'd0;
  logic [0:63] val_a = '0;
  logic [0:63] val_b = '0;
  logic        set_cc = 1'b0;
  logic [3:0]  cond_fun = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [0:63] val_e;
  logic        cnd;
  logic        err;
  logic [0:2]  cc;

  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [3:0]  n_alu_fun = 4'd0;
  logic [0:7]  n_val_a = '0;
  logic [0:7]  n_val_b = '0;
  logic        n_set_cc = 1'b0;
  logic [3:0]  n_cond_fun = 4'd0;
  logic        n_out_valid;
  logic        n_out_ready = 1'b1;
  logic [0:7]  n_val_e;
  logic        n_cnd;
  logic        n_err;
  logic [0:2]  n_cc;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [2:0] mcc = 3'b100;
  logic [63:0] first_v;

  always #5 clk = ~clk;

  alu_cc_unit #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_fun(alu_fun), .val_a(val_a),
    .val_b(val_b), .set_cc(set_cc),
    .cond_fun(cond_fun),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .val_e(val_e), .cnd(cnd),
    .err(err), .cc(cc)
  );

  alu_cc_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .alu_fun(n_alu_fun), .val_a(n_val_a),
    .val_b(n_val_b), .set_cc(n_set_cc),
    .cond_fun(n_cond_fun),
    .out_valid(n_out_valid),
    .out_ready(n_out_ready),
    .val_e(n_val_e), .cnd(n_cnd),
    .err(n_err), .cc(n_cc)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               tag, obs, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [3:0]  f,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        sc,
    input logic [3:0]  cf,
    input logic [2:0]  c
  );
    exp_t x;
    logic [63:0] r;
    logic z, s, o, bad, cn, lt;
    bad = (f > 4'd3) || (cf > 4'd6);
    case (f)
      4'd0: r = b + a;
      4'd1: r = b - a;
      4'd2: r = b & a;
      4'd3: r = b ^ a;
      default: r = 64'd0;
    endcase
    z = (r == 64'd0);
    s = r[63];
    if (f == 4'd0)
      o = (a[63] == b[63]) && (r[63] != a[63]);
    else if (f == 4'd1)
      o = (a[63] != b[63]) && (r[63] != b[63]);
    else
      o = 1'b0;
    lt = c[1] ^ c[0];
    case (cf)
      4'd0: cn = 1'b1;
      4'd1: cn = lt | c[2];
      4'd2: cn = lt;
      4'd3: cn = c[2];
      4'd4: cn = !c[2];
      4'd5: cn = !lt;
      4'd6: cn = !lt && !c[2];
      default: cn = 1'b0;
    endcase
    x.v  = bad ? 64'd0 : r;
    x.c  = bad ? 1'b0 : cn;
    x.e  = bad;
    x.cc = (sc && !bad) ? {z, s, o} : c;
    return x;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("sb_val_e", val_e, x.v);
        check("sb_cnd", 64'(cnd), 64'(x.c));
        check("sb_err", 64'(err), 64'(x.e));
        check("sb_cc", 64'(cc), 64'(x.cc));
      end
    end
  end

  task automatic send(input logic [3:0]  f,
                      input logic [63:0] a,
                      input logic [63:0] b,
                      input logic        sc,
                      input logic [3:0]  cf);
    exp_t x;
    int n;
    bit ok;
    in_valid = 1'b1;
    alu_fun  = f;
    val_a    = a;
    val_b    = b;
    set_cc   = sc;
    cond_fun = cf;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      x = model(f, a, b, sc, cf, mcc);
      mcc = x.cc;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ok) check("lat_valid",
                  64'(out_valid), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mcc = 3'b100;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0)
      check("drain_timeout", 64'd0, 64'd1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_val_e", val_e, 64'd0);
    check("rst_cnd", 64'(cnd), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cc", 64'(cc), 64'd4);
    check("rst_ready", 64'(in_ready), 64'd1);

    send(4'd0, 64'd1,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    check("ovf_val", val_e,
          64'h8000_0000_0000_0000);
    check("ovf_cc", 64'(cc), 64'd3);
    drain();

    send(4'd1, 64'd5, 64'd5, 1'b1, 4'd0);
    send(4'd1, 64'd7, 64'd3, 1'b0, 4'd3);
    check("sub_val", val_e,
          64'hFFFF_FFFF_FFFF_FFFC);
    check("sub_cnd", 64'(cnd), 64'd1);
    check("sub_cc", 64'(cc), 64'd4);
    drain();

    do_reset();
    for (int i = 0; i < 7; i++)
      send(4'd2, 64'd0, 64'd0, 1'b0, 4'(i));
    drain();

    for (int i = 0; i < 8; i++)
      send(4'($urandom_range(0, 3)),
           {$urandom, $urandom},
           {$urandom, $urandom},
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 6)));
    drain();

    out_ready = 1'b0;
    send(4'd3, 64'hF0F0, 64'h0FF0, 1'b1, 4'd0);
    first_v = 64'hFF00;
    fork
      send(4'd0, 64'd2, 64'd40, 1'b1, 4'd6);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_ready", 64'(in_ready), 64'd0);
          check("bp_hold", val_e, first_v);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("bp_second", val_e, 64'd42);
    drain();
    @(posedge clk);
    #1;
    check("idle_clear", 64'(out_valid), 64'd0);

    send(4'd4, 64'd1, 64'd1, 1'b1, 4'd0);
    check("bad_fun_err", 64'(err), 64'd1);
    check("bad_fun_val", val_e, 64'd0);
    send(4'd0, 64'd0, 64'd0, 1'b1, 4'd7);
    check("bad_cond_err", 64'(err), 64'd1);
    check("bad_cond_cnd", 64'(cnd), 64'd0);
    drain();

    send(4'd1, 64'd9, 64'd1, 1'b1, 4'd0);
    drain();
    out_ready = 1'b0;
    send(4'd0, 64'd1, 64'd1, 1'b1, 4'd0);
    do_reset();
    check("rst_mid_valid",
          64'(out_valid), 64'd0);
    check("rst_mid_cc", 64'(cc), 64'd4);
    out_ready = 1'b1;

    n_alu_fun  = 4'd0;
    n_val_a    = 8'h01;
    n_val_b    = 8'h7F;
    n_set_cc   = 1'b1;
    n_cond_fun = 4'd0;
    n_in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_in_valid = 1'b0;
    check("w8_valid", 64'(n_out_valid), 64'd1);
    check("w8_val", 64'(n_val_e), 64'h80);
    check("w8_cc", 64'(n_cc), 64'd3);
    check("w8_err", 64'(n_err), 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
